psk_mod_serial: RTL

Parametrised BPSK/QPSK modulator, successor to the single-symbol-per-word modulator on the 16.384 MHz TX path. Accepts whole AXIS words, serialises them MSB-first into 1- or 2-bit symbols at a programmable samples-per-symbol rate, and optionally differentially encodes (DBPSK/DQPSK). Maps each symbol onto the I/Q carrier with saturating negation and flags source underrun. Sits between the 16.384 MHz TX FIFO and the DAC/upsampler.

---
 rtl/psk_pkg.sv | 41 ++++
 rtl/psk_phase_mapper.sv | 58 +++++
 rtl/psk_mod_serial.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/psk_pkg.sv
`default_nettype none
// =============================================================================
// Module   : psk_pkg
// Brief    : Shared phase-index types, tuser bit positions and symbol helpers
// Revision : 1.0
// =============================================================================
package psk_pkg;

  localparam int PHASE_W    = 2;
  localparam int TUSER_BPSK = 0;
  localparam int TUSER_DIFF = 1;

  typedef logic [PHASE_W-1:0] phase_t;

  // Gray-coded QPSK dibit to quarter-turn phase index
  function automatic phase_t gray_to_idx(input logic [1:0] sym);
    phase_t idx;
    case (sym)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic phase_t bpsk_to_idx(input logic bit_val);
    return bit_val ? 2'd0 : 2'd2;
  endfunction

  // x is a sign-extended WIDTH-bit value; the most negative code maps to +max
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int width);
    logic signed [31:0] max_pos;
    max_pos = (32'sd1 <<< (width - 1)) - 32'sd1;
    if (x < -max_pos) return max_pos;
    return -x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psk_phase_mapper.sv
`default_nettype none
// =============================================================================
// Module   : psk_phase_mapper
// Brief    : Rotates the I/Q carrier by a quarter-turn index, one register stage
// Revision : 1.0
// =============================================================================
module psk_phase_mapper
  import psk_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  phase_t                  idx,
  input  logic                    vld,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  output logic signed [WIDTH-1:0] out_I,
  output logic signed [WIDTH-1:0] out_Q
);

  logic signed [31:0]      ci_ext;
  logic signed [31:0]      cq_ext;
  logic signed [WIDTH-1:0] ci_neg;
  logic signed [WIDTH-1:0] cq_neg;
  logic signed [WIDTH-1:0] map_I;
  logic signed [WIDTH-1:0] map_Q;

  assign ci_ext = {{(32-WIDTH){carrier_I[WIDTH-1]}}, carrier_I};
  assign cq_ext = {{(32-WIDTH){carrier_Q[WIDTH-1]}}, carrier_Q};
  assign ci_neg = WIDTH'(sat_neg(ci_ext, WIDTH));
  assign cq_neg = WIDTH'(sat_neg(cq_ext, WIDTH));

  always_comb begin
    map_I = '0;
    map_Q = '0;
    if (vld) begin
      case (idx)
        2'd0: begin map_I = carrier_I; map_Q = carrier_Q; end
        2'd1: begin map_I = carrier_Q; map_Q = ci_neg;    end
        2'd2: begin map_I = ci_neg;    map_Q = cq_neg;    end
        default: begin map_I = cq_neg; map_Q = carrier_I; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_I <= '0;
      out_Q <= '0;
    end else begin
      out_I <= map_I;
      out_Q <= map_Q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psk_mod_serial.sv
`default_nettype none
// =============================================================================
// Module   : psk_mod_serial
// Brief    : Serialising BPSK/QPSK modulator with optional differential coding
// Revision : 1.0
// =============================================================================
module psk_mod_serial
  import psk_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int BYTES    = 1,
  parameter int SPS_LOG2 = 4
) (
  input  logic                    clk_16M384,
  input  logic                    rst_16M384,
  input  logic [8*BYTES-1:0]      s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [1:0]              s_tuser,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  input  logic [SPS_LOG2-1:0]     DELAY_CNT,
  output logic signed [WIDTH-1:0] out_I,
  output logic signed [WIDTH-1:0] out_Q,
  output logic                    out_vld,
  output logic                    out_last,
  output logic                    out_is_bpsk,
  output logic [1:0]              out_sym,
  output logic                    out_sym_stb,
  output logic                    out_underrun,
  output logic                    out_clk_sym
);

  localparam int              BITS   = 8 * BYTES;
  localparam int              BL_W   = $clog2(BITS + 1);
  localparam logic [BL_W-1:0] BITS_L = BL_W'(BITS);

  logic [SPS_LOG2-1:0] cnt;
  logic [SPS_LOG2-1:0] cnt_nxt;
  logic                bnd;
  logic                bnd_nxt;
  logic [BITS-1:0]     word_sr;
  logic [BITS-1:0]     src_word;
  logic [BITS-1:0]     shifted;
  logic [BL_W-1:0]     bits_left;
  logic [BL_W-1:0]     bits_src;
  logic [BL_W-1:0]     bps;
  logic [BL_W-1:0]     left_after;
  logic [BL_W-1:0]     bits_left_nxt;
  logic                tlast_q;
  logic                bpsk_q;
  logic                diff_q;
  phase_t              phase_ref;
  phase_t              delta;
  phase_t              phase_sum;
  phase_t              idx_new;
  logic                mid_word;
  logic                transfer;
  logic                emit;
  logic                use_bpsk;
  logic                use_diff;
  logic                use_last;
  logic                last_new;
  logic [1:0]          sym_new;

  logic [1:0]          sym1;
  logic                vld1;
  logic                last1;
  logic                isb1;
  logic                stb1;
  logic                und1;
  phase_t              idx1;

  // The boundary flag is registered alongside s_tready so both always agree,
  // even in the cycle where DELAY_CNT is changed under a running counter.
  assign cnt_nxt     = cnt + 1'b1;
  assign bnd_nxt     = (cnt_nxt == DELAY_CNT);
  assign mid_word    = (bits_left != '0);
  assign transfer    = s_tready & s_tvalid;
  assign emit        = bnd & (mid_word | transfer);
  assign out_clk_sym = cnt[SPS_LOG2-1];

  always_comb begin
    src_word  = mid_word ? word_sr   : s_tdata;
    use_bpsk  = mid_word ? bpsk_q    : s_tuser[TUSER_BPSK];
    use_diff  = mid_word ? diff_q    : s_tuser[TUSER_DIFF];
    use_last  = mid_word ? tlast_q   : s_tlast;
    bits_src  = mid_word ? bits_left : BITS_L;
    bps       = use_bpsk ? BL_W'(1) : BL_W'(2);
    left_after = bits_src - bps;
    sym_new   = use_bpsk ? {1'b0, src_word[BITS-1]} : src_word[BITS-1 -: 2];
    shifted   = use_bpsk ? {src_word[BITS-2:0], 1'b0} : {src_word[BITS-3:0], 2'b00};
    delta     = use_bpsk ? bpsk_to_idx(sym_new[0]) : gray_to_idx(sym_new);
    phase_sum = phase_ref + delta;
    idx_new   = use_diff ? phase_sum : delta;
    last_new  = use_last & (left_after == '0);
    bits_left_nxt = emit ? left_after : bits_left;
  end

  always_ff @(posedge clk_16M384 or negedge rst_16M384) begin
    if (!rst_16M384) begin
      cnt       <= '0;
      bnd       <= 1'b0;
      s_tready  <= 1'b0;
      word_sr   <= '0;
      bits_left <= '0;
      tlast_q   <= 1'b0;
      bpsk_q    <= 1'b0;
      diff_q    <= 1'b0;
      phase_ref <= '0;
      sym1      <= '0;
      vld1      <= 1'b0;
      last1     <= 1'b0;
      isb1      <= 1'b0;
      idx1      <= '0;
      stb1      <= 1'b0;
      und1      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      bnd      <= bnd_nxt;
      s_tready <= bnd_nxt & (bits_left_nxt == '0);
      stb1     <= bnd;
      und1     <= bnd & ~emit;
      if (emit) begin
        word_sr   <= shifted;
        bits_left <= left_after;
        if (!mid_word) begin
          tlast_q <= s_tlast;
          bpsk_q  <= s_tuser[TUSER_BPSK];
          diff_q  <= s_tuser[TUSER_DIFF];
        end
        sym1  <= sym_new;
        vld1  <= 1'b1;
        last1 <= last_new;
        isb1  <= use_bpsk;
        idx1  <= idx_new;
        if (last_new)      phase_ref <= '0;
        else if (use_diff) phase_ref <= phase_sum;
      end else if (bnd) begin
        sym1      <= '0;
        vld1      <= 1'b0;
        last1     <= 1'b0;
        isb1      <= 1'b0;
        idx1      <= '0;
        phase_ref <= '0;
      end
    end
  end

  always_ff @(posedge clk_16M384 or negedge rst_16M384) begin
    if (!rst_16M384) begin
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
      out_is_bpsk  <= 1'b0;
      out_sym      <= '0;
      out_sym_stb  <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      out_vld      <= vld1;
      out_last     <= last1;
      out_is_bpsk  <= isb1;
      out_sym      <= sym1;
      out_sym_stb  <= stb1;
      out_underrun <= und1;
    end
  end

  psk_phase_mapper #(
    .WIDTH (WIDTH)
  ) u_mapper (
    .clk       (clk_16M384),
    .rst_n     (rst_16M384),
    .idx       (idx1),
    .vld       (vld1),
    .carrier_I (carrier_I),
    .carrier_Q (carrier_Q),
    .out_I     (out_I),
    .out_Q     (out_Q)
  );

endmodule
`default_nettype wire
